// File: rtl/tip_hello_reset_seq.sv
`default_nettype none
// ============================================================================
// Module   : tip_hello_reset_seq
// Brief    : Power-on / soft reset sequencer. Waits for a stable PLL lock,
//            releases the system reset, then releases the DRAM reset after a
//            fixed delay. Supports a soft reset request from RUN.
// Options  : TIP_HELLO_RESET_SEQ_LOCK_LOSS_EN - when defined, loss of lock
//            after stabilisation drops all resets and restarts the sequence.
// Revision : 1.0 - initial release
// ============================================================================
module tip_hello_reset_seq #(
    parameter int STABLE_CYCLES = 16,   // 1..1023
    parameter int DRAM_DELAY    = 8,    // 1..1023
    parameter int SOFT_PULSE    = 4     // 1..1023
) (
    input  logic clk,
    input  logic rstnn,
    input  logic pll_locked,
    input  logic soft_reset_req,
    output logic rstnn_system,
    output logic rstnn_dram,
    output logic reset_done
);

    localparam int         c_cnt_w        = 10;

    localparam logic [2:0] c_st_wait_lock = 3'd0;
    localparam logic [2:0] c_st_stabilize = 3'd1;
    localparam logic [2:0] c_st_rel_sys   = 3'd2;
    localparam logic [2:0] c_st_run       = 3'd3;
    localparam logic [2:0] c_st_soft      = 3'd4;

    // Terminal counts: each timed state exits when the counter hits N-1
    localparam logic [c_cnt_w-1:0] c_stab_last = c_cnt_w'(STABLE_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_dram_last = c_cnt_w'(DRAM_DELAY - 1);
    localparam logic [c_cnt_w-1:0] c_soft_last = c_cnt_w'(SOFT_PULSE - 1);

    logic               r_lock_meta;
    logic               r_lock_s;
    logic [2:0]         r_state;
    logic [2:0]         w_state_nxt;
    logic [c_cnt_w-1:0] r_cnt;
    logic [c_cnt_w-1:0] w_cnt_nxt;
    logic               r_rstnn_system;
    logic               r_rstnn_dram;
    logic               r_reset_done;
    logic               w_sys_nxt;
    logic               w_dram_nxt;
    logic               w_done_nxt;
    logic               w_lock_lost;

`ifdef TIP_HELLO_RESET_SEQ_LOCK_LOSS_EN
    // Lock loss is honoured in every post-stabilisation state
    assign w_lock_lost = ~r_lock_s;
`else
    // Lock is only watched in WAIT_LOCK / STABILIZE
    assign w_lock_lost = 1'b0;
`endif

    // Two-flop synchronizer for the asynchronous PLL lock indicator
    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) begin
            r_lock_meta <= 1'b0;
            r_lock_s    <= 1'b0;
        end else begin
            r_lock_meta <= pll_locked;
            r_lock_s    <= r_lock_meta;
        end
    end

    // State, shared counter and registered reset outputs
    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) begin
            r_state        <= c_st_wait_lock;
            r_cnt          <= '0;
            r_rstnn_system <= 1'b0;
            r_rstnn_dram   <= 1'b0;
            r_reset_done   <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_cnt          <= w_cnt_nxt;
            r_rstnn_system <= w_sys_nxt;
            r_rstnn_dram   <= w_dram_nxt;
            r_reset_done   <= w_done_nxt;
        end
    end

    // Next-state and counter logic; lock loss has priority over soft request
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            c_st_wait_lock: begin
                if (r_lock_s) begin
                    w_state_nxt = c_st_stabilize;
                    w_cnt_nxt   = '0;
                end
            end
            c_st_stabilize: begin
                if (!r_lock_s) begin
                    w_state_nxt = c_st_wait_lock;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == c_stab_last) begin
                    w_state_nxt = c_st_rel_sys;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = r_cnt + 1'b1;
                end
            end
            c_st_rel_sys: begin
                if (w_lock_lost) begin
                    w_state_nxt = c_st_wait_lock;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == c_dram_last) begin
                    w_state_nxt = c_st_run;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = r_cnt + 1'b1;
                end
            end
            c_st_run: begin
                if (w_lock_lost) begin
                    w_state_nxt = c_st_wait_lock;
                    w_cnt_nxt   = '0;
                end else if (soft_reset_req) begin
                    w_state_nxt = c_st_soft;
                    w_cnt_nxt   = '0;
                end
            end
            c_st_soft: begin
                if (w_lock_lost) begin
                    w_state_nxt = c_st_wait_lock;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == c_soft_last) begin
                    w_state_nxt = c_st_stabilize;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = c_st_wait_lock;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Outputs decoded from the next state so they change on the transition edge
    always_comb begin
        w_sys_nxt  = (w_state_nxt == c_st_rel_sys) || (w_state_nxt == c_st_run);
        w_dram_nxt = (w_state_nxt == c_st_run);
        w_done_nxt = (w_state_nxt == c_st_run);
    end

    assign rstnn_system = r_rstnn_system;
    assign rstnn_dram   = r_rstnn_dram;
    assign reset_done   = r_reset_done;

endmodule
`default_nettype wire
